// File: rtl/spi_cmd_master_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_master_pkg
//   Shared definitions for the SPI command master:
//     - state_t          : master FSM states
//     - OP_*             : request opcodes carried in req_op
//     - FRAME_BITS       : serialised frame width ({op, payload})
//     - DATA_BITS        : payload / captured byte width
//     - CNT_W            : width of the per-phase cycle counter
//   Optional feature macro used by the design: SPI_CMD_MASTER_STATUS_EN.
// -----------------------------------------------------------------------------
package spi_cmd_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = DATA_BITS + 2;
    localparam int unsigned CNT_W      = 4;

    // Last counter value of each counted phase.
    localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CAPTURE_LAST = CNT_W'(DATA_BITS - 1);

    // Only a read-data command turns the bus around to receive a byte.
    function automatic logic is_read_data(input logic [1:0] op);
        return (op == OP_RD_DATA);
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// -----------------------------------------------------------------------------
// spi_shift_reg
//   Parallel-load, MSB-out, serial-in shift register shared by the MOSI
//   serialiser and the MISO capture path of spi_cmd_master.
//
//   Ports:
//     clk            in   system clock
//     rst_n          in   asynchronous active-low reset
//     i_load         in   load i_load_data (has priority over shifting)
//     i_load_data    in   WIDTH-bit parallel load value
//     i_shift_en     in   shift left by one, i_serial_in enters at bit 0
//     i_serial_in    in   serial input bit
//     o_msb          out  current MSB (next bit to be sent)
//     o_capture_byte out  low CAP_W bits as they will be after the next shift
// -----------------------------------------------------------------------------
module spi_shift_reg #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned CAP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift_en,
    input  logic             i_serial_in,
    output logic             o_msb,
    output logic [CAP_W-1:0] o_capture_byte
);

    logic [WIDTH-1:0] r_data;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
        end else if (i_shift_en) begin
            r_data <= {r_data[WIDTH-2:0], i_serial_in};
        end
    end

    assign o_msb = r_data[WIDTH-1];

    // Lets the owner register a complete captured byte on the same edge that
    // samples its final bit.
    assign o_capture_byte = {r_data[CAP_W-2:0], i_serial_in};

endmodule

// File: rtl/spi_cmd_master.sv
// -----------------------------------------------------------------------------
// spi_cmd_master
//   Single-slave SPI command master. Accepts one request at a time, sends a
//   command-select bit followed by the 10-bit frame {op, payload} MSB first,
//   and for read-data commands waits RD_WAIT cycles and captures one byte
//   from MISO, MSB first. All bus and handshake outputs are registered.
//
//   Parameter:
//     RD_WAIT      cycles between last command bit and first captured bit
//                  (legal 1..15)
//
//   Ports:
//     clk          in   system clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     req_valid    in   host request present
//     req_ready    out  high only in IDLE; request accepted on valid&&ready
//     req_op       in   opcode (OP_WR_ADDR/OP_WR_DATA/OP_RD_ADDR/OP_RD_DATA)
//     req_payload  in   address or data byte
//     rsp_valid    out  one-cycle pulse in the DONE cycle of a read-data frame
//     rsp_data     out  last captured byte, held until the next capture
//     SS_n         out  slave select, active low
//     MOSI         out  serial data to slave (0 whenever SS_n is high)
//     MISO         in   serial data from slave
//     busy         out  high in every state except IDLE   (status build only)
//     frame_cnt    out  completed frames, wraps at 16 bits (status build only)
//
//   Optional feature macro: SPI_CMD_MASTER_STATUS_EN adds busy/frame_cnt.
// -----------------------------------------------------------------------------
module spi_cmd_master
    import spi_cmd_master_pkg::*;
#(
    parameter int unsigned RD_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_payload,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        SS_n,
    output logic        MOSI,
    input  logic        MISO
`ifdef SPI_CMD_MASTER_STATUS_EN
    ,
    output logic        busy,
    output logic [15:0] frame_cnt
`endif
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_WAIT - 1);

    state_t                 r_state;
    logic [1:0]             r_op;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ss_n;
    logic                   r_mosi;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic [DATA_BITS-1:0]   r_rsp_data;

    logic                   w_accept;
    logic                   w_shift_en;
    logic                   w_sr_msb;
    logic [DATA_BITS-1:0]   w_capture_byte;

    assign w_accept = req_valid && r_req_ready && (r_state == ST_IDLE);

    // Shift on the START edge (presents frame bit 9), on every SHIFT edge but
    // the last (frame bit 0 is already on MOSI), and on every CAPTURE edge.
    // NOTE: every variable driven here gets a default first so no latch is
    // inferred for the state values not listed.
    always_comb begin
        w_shift_en = 1'b0;
        case (r_state)
            ST_START:   w_shift_en = 1'b1;
            ST_SHIFT:   w_shift_en = (r_cnt != SHIFT_LAST);
            ST_CAPTURE: w_shift_en = 1'b1;
            default:    w_shift_en = 1'b0;
        endcase
    end

    spi_shift_reg #(
        .WIDTH (FRAME_BITS),
        .CAP_W (DATA_BITS)
    ) u_shift_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_load         (w_accept),
        .i_load_data    ({req_op, req_payload}),
        .i_shift_en     (w_shift_en),
        .i_serial_in    (MISO),
        .o_msb          (w_sr_msb),
        .o_capture_byte (w_capture_byte)
    );

    // Master FSM. Outputs are assigned on the edge that enters the state they
    // belong to, so they line up with r_state cycle for cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_WR_ADDR;
            r_cnt       <= '0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ss_n <= 1'b1;
                    r_mosi <= 1'b0;
                    if (w_accept) begin
                        r_op        <= req_op;
                        r_req_ready <= 1'b0;
                        r_ss_n      <= 1'b0;
                        r_mosi      <= req_op[1];   // command-select bit
                        r_state     <= ST_START;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end

                ST_START: begin
                    r_mosi  <= w_sr_msb;
                    r_cnt   <= '0;
                    r_state <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (r_cnt == SHIFT_LAST) begin
                        r_mosi <= 1'b0;
                        r_cnt  <= '0;
                        if (is_read_data(r_op)) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_ss_n  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_mosi <= w_sr_msb;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    if (r_cnt == CAPTURE_LAST) begin
                        r_cnt       <= '0;
                        r_ss_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_capture_byte;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_cnt       <= '0;
                    r_ss_n      <= 1'b1;
                    r_mosi      <= 1'b0;
                    r_req_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;

`ifdef SPI_CMD_MASTER_STATUS_EN
    logic [15:0] r_frame_cnt;

    // Counts on the edge leaving DONE; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (r_state == ST_DONE) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign frame_cnt = r_frame_cnt;
`endif

endmodule
